ddsm_seg_acc: RTL and testbench



---
 rtl/ddsm_seg_acc_pkg.sv | 28 ++
 rtl/ddsm_seg_add.sv | 35 +++
 rtl/ddsm_seg_acc.sv | 48 ++++
 tb/tb_ddsm_seg_acc.sv | 114 +++++++++++
 4 files changed

// File: rtl/ddsm_seg_acc_pkg.sv
// Shared constants for the segmented MASH DDSM: segment geometry and the
// inter-segment skew that the skew stage and the accumulators must agree on.
package ddsm_seg_acc_pkg;

  localparam int SEG_W = 8;
  localparam int NSEG  = 3;
  localparam int ACC_W = SEG_W * NSEG;

  // Cycles each segment trails the LSB; equals the carry latency per segment.
  localparam int SKEW_LSB = 0;
  localparam int SKEW_ISB = 1;
  localparam int SKEW_MSB = 2;

  typedef enum logic [1:0] {
    SEG_LSB = 2'd0,
    SEG_ISB = 2'd1,
    SEG_MSB = 2'd2
  } seg_idx_e;

  function automatic int seg_skew(input seg_idx_e idx);
    case (idx)
      SEG_LSB: return SKEW_LSB;
      SEG_ISB: return SKEW_ISB;
      default: return SKEW_MSB;
    endcase
  endfunction

endpackage

// File: rtl/ddsm_seg_add.sv
// One accumulator segment: registered P_SEG_W-bit adder with carry in/out and
// synchronous reset/clear.
module ddsm_seg_add
  import ddsm_seg_acc_pkg::*;
#(
  parameter int P_SEG_W = SEG_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic [P_SEG_W-1:0] i_add,
  input  logic               i_ci,
  output logic [P_SEG_W-1:0] o_acc,
  output logic               o_co
);

  logic [P_SEG_W-1:0] r_acc;
  logic               r_co;
  logic [P_SEG_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_add} + {{P_SEG_W{1'b0}}, i_ci};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_acc <= '0;
      r_co  <= 1'b0;
    end else begin
      {r_co, r_acc} <= w_sum;
    end
  end

  assign o_acc = r_acc;
  assign o_co  = r_co;

endmodule

// File: rtl/ddsm_seg_acc.sv
// First MASH accumulator stage on a skewed segmented word; carries between
// segments are registered so the input skew lines up with the carry latency.
module ddsm_seg_acc
  import ddsm_seg_acc_pkg::*;
#(
  parameter int P_SEG_W = SEG_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic [P_SEG_W-1:0] i_lsb,
  input  logic [P_SEG_W-1:0] i_isb,
  input  logic [P_SEG_W-1:0] i_msb,
  output logic [P_SEG_W-1:0] o_res_lsb,
  output logic [P_SEG_W-1:0] o_res_isb,
  output logic [P_SEG_W-1:0] o_res_msb,
  output logic               o_carry
);

  logic [NSEG-1:0][P_SEG_W-1:0] w_seg_in;
  logic [NSEG-1:0][P_SEG_W-1:0] w_acc;
  logic [NSEG-1:0]              w_ci;
  logic [NSEG-1:0]              w_co;

  assign w_seg_in = {i_msb, i_isb, i_lsb};
  // Each segment's carry-in is the registered carry-out of the one below.
  assign w_ci     = {w_co[NSEG-2:0], 1'b0};

  generate
    for (genvar g = 0; g < NSEG; g++) begin : g_seg
      ddsm_seg_add #(.P_SEG_W(P_SEG_W)) u_seg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr),
        .i_add (w_seg_in[g]),
        .i_ci  (w_ci[g]),
        .o_acc (w_acc[g]),
        .o_co  (w_co[g])
      );
    end
  endgenerate

  assign o_res_lsb = w_acc[SEG_LSB];
  assign o_res_isb = w_acc[SEG_ISB];
  assign o_res_msb = w_acc[SEG_MSB];
  assign o_carry   = w_co[SEG_MSB];

endmodule

// File: tb/tb_ddsm_seg_acc.sv
// Randomized + directed check of ddsm_seg_acc against a de-skewing 24-bit
// running-sum model indexed by the cycle each sample's LSB is presented.
module tb_ddsm_seg_acc;

  localparam int NCYC = 10400;

  logic       i_clk, i_rst, i_clr;
  logic [7:0] i_lsb, i_isb, i_msb;
  logic [7:0] o_res_lsb, o_res_isb, o_res_msb;
  logic       o_carry;

  ddsm_seg_acc #(.P_SEG_W(8)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_clr),
    .i_lsb     (i_lsb),
    .i_isb     (i_isb),
    .i_msb     (i_msb),
    .o_res_lsb (o_res_lsb),
    .o_res_isb (o_res_isb),
    .o_res_msb (o_res_msb),
    .o_carry   (o_carry)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [23:0] samp [0:NCYC];
  logic [23:0] ssum [0:NCYC];
  logic        cy   [0:NCYC];
  int cyc, base, n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Segments of samples older than the last reset/clear are driven as 0,
  // i.e. upstream restarts its skewed stream together with this stage.
  task automatic step(input logic rst, input logic clr, input logic [23:0] v);
    logic [23:0] prev;
    samp[cyc] = v;
    i_rst = rst;
    i_clr = clr;
    i_lsb = v[7:0];
    i_isb = (cyc - 1 >= base) ? samp[cyc-1][15:8]  : 8'h00;
    i_msb = (cyc - 2 >= base) ? samp[cyc-2][23:16] : 8'h00;
    if (rst || clr) begin
      base  = cyc + 1;
      i_isb = 8'($urandom);
      i_msb = 8'($urandom);
    end else begin
      prev = (cyc - 1 >= base) ? ssum[cyc-1] : 24'h0;
      {cy[cyc], ssum[cyc]} = {1'b0, prev} + {1'b0, v};
    end
    @(posedge i_clk);
    #1;
    chk("res_lsb", 32'(o_res_lsb), (cyc     >= base) ? 32'(ssum[cyc][7:0])     : 32'h0);
    chk("res_isb", 32'(o_res_isb), (cyc - 1 >= base) ? 32'(ssum[cyc-1][15:8])  : 32'h0);
    chk("res_msb", 32'(o_res_msb), (cyc - 2 >= base) ? 32'(ssum[cyc-2][23:16]) : 32'h0);
    chk("carry",   32'(o_carry),   (cyc - 2 >= base) ? 32'(cy[cyc-2])          : 32'h0);
    cyc++;
  endtask

  task automatic run(input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, v);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    i_rst = 1'b0; i_clr = 1'b0; i_lsb = '0; i_isb = '0; i_msb = '0;
    samp[0] = '0; samp[1] = '0;
    cyc  = 2;
    base = 2;
    // Reset held two cycles with random inputs.
    step(1'b1, 1'b0, 24'($urandom));
    step(1'b1, 1'b0, 24'($urandom));
    // Half-scale: carry every other sample.
    run(24'h800000, 8);
    step(1'b0, 1'b1, 24'h0);
    // Quarter-scale: carry every fourth sample.
    run(24'h400000, 12);
    step(1'b0, 1'b1, 24'h0);
    // Full ripple from LSB to MSB.
    step(1'b0, 1'b0, 24'hFFFFFF);
    step(1'b0, 1'b0, 24'h000001);
    run(24'h0, 4);
    // Maximum input: carry on all but the first sample.
    step(1'b0, 1'b1, 24'h0);
    run(24'hFFFFFF, 8);
    // Clear pulse mid-stream.
    run(24'h555555, 6);
    step(1'b0, 1'b1, 24'h555555);
    run(24'h555555, 8);
    // Reset and clear together mid-stream.
    run(24'hABCDEF, 3);
    step(1'b1, 1'b1, 24'hABCDEF);
    run(24'hABCDEF, 4);
    // Random stream with occasional reset / clear / both.
    for (int i = 0; i < 10000; i++) begin
      int r;
      logic [23:0] v;
      r = int'($urandom_range(0, 299));
      v = (r % 3 == 0) ? 24'($urandom) | 24'hF00000 : 24'($urandom);
      step(r == 0 || r == 2, r == 1 || r == 2, v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
